// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU program sequencer: state encoding, size defaults
// and the jump-target builder used by the decoder-facing address logic.
package mpu_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } seq_state_t;

    localparam int PC_W_DEFAULT        = 8;
    localparam int STACK_DEPTH_DEFAULT = 4;

    // Jump targets are 4-bit aligned pages: nibble in the top bits, zeros below.
    function automatic logic [31:0] jump_target(input int pc_w, input logic [3:0] nibble);
        return {28'b0, nibble} << (pc_w - 4);
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses for call/ret. Overflowing pushes and underflowing
// pops are dropped; the caller reports them.
module return_stack
    import mpu_pkg::*;
#(
    parameter int W     = PC_W_DEFAULT,
    parameter int DEPTH = STACK_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         sync_reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int SP_W = $clog2(DEPTH) + 1;

    logic [W-1:0]      mem [DEPTH];
    logic [SP_W-1:0]   sp_reg;
    logic [SP_W-2:0]   top_idx;
    logic [SP_W-2:0]   wr_idx;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (sp_reg == '0);
    assign full    = (sp_reg == SP_W'(DEPTH));
    assign top_idx = (SP_W-1)'(sp_reg - SP_W'(1));
    assign wr_idx  = sp_reg[SP_W-2:0];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && !full && !pop;

    // Top of stack must be visible in the same cycle as ret, so the read is combinational.
    assign top = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            sp_reg <= '0;
        end else if (pop_ok) begin
            sp_reg <= sp_reg - SP_W'(1);
        end else if (push_ok) begin
            sp_reg <= sp_reg + SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset_n && push_ok) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program-memory address sequencer: PC, jumps, hold/resume and optional
// call/return stack (enabled by defining MPU_CALL_STACK_EN).
module program_sequencer
    import mpu_pkg::*;
#(
    parameter int PC_W        = PC_W_DEFAULT,
    parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            sync_reset_n,
    input  logic            jmp,
    input  logic            jmp_nz,
    input  logic [3:0]      jmp_addr,
    input  logic            dont_jmp,
    input  logic            call,
    input  logic            ret,
    input  logic            hold,
    output logic [PC_W-1:0] pm_addr,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     instr_count,
    output logic            stack_err
);

    seq_state_t      state_reg, state_next;
    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pend_addr_reg;
    logic [15:0]     count_reg;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] run_addr;
    logic            run_cycle;

    assign target    = PC_W'(jump_target(PC_W, jmp_addr));
    assign pc_inc    = pc_reg + PC_W'(1);
    assign run_cycle = (state_reg == RUN);

`ifdef MPU_CALL_STACK_EN
    logic [PC_W-1:0] stack_top;
    logic            stack_full, stack_empty;
    logic            push_req, pop_req, err_req;
    logic            err_reg;

    always_comb begin
        run_addr = pc_inc;
        push_req = 1'b0;
        pop_req  = 1'b0;
        err_req  = 1'b0;
        if (ret) begin
            if (stack_empty) begin
                err_req = 1'b1;
            end else begin
                run_addr = stack_top;
                pop_req  = 1'b1;
            end
        end else if (call) begin
            run_addr = target;
            if (stack_full) begin
                err_req = 1'b1;
            end else begin
                push_req = 1'b1;
            end
        end else if (jmp || (jmp_nz && !dont_jmp)) begin
            run_addr = target;
        end
    end

    // Stack side effects commit on every RUN cycle, including the one that enters HOLD.
    return_stack #(.W(PC_W), .DEPTH(STACK_DEPTH)) u_return_stack (
        .clk          (clk),
        .sync_reset_n (sync_reset_n),
        .push         (push_req && run_cycle),
        .pop          (pop_req && run_cycle),
        .push_data    (pc_inc),
        .top          (stack_top),
        .full         (stack_full),
        .empty        (stack_empty)
    );

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            err_reg <= 1'b0;
        end else if (run_cycle && err_req) begin
            err_reg <= 1'b1;
        end
    end

    assign stack_err = err_reg;
`else
    logic unused_inputs;
    localparam int unused_stack_depth = STACK_DEPTH;

    always_comb begin
        run_addr = pc_inc;
        if (jmp || (jmp_nz && !dont_jmp)) begin
            run_addr = target;
        end
    end

    assign unused_inputs = ^{call, ret};
    assign stack_err     = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        pm_addr    = pc_reg;
        unique case (state_reg)
            RUN: begin
                if (hold) begin
                    state_next = HOLD;
                end else begin
                    pm_addr = run_addr;
                end
            end
            HOLD: begin
                if (!hold) begin
                    pm_addr    = pend_addr_reg;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
        if (!sync_reset_n) begin
            pm_addr    = '0;
            state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state_reg     <= RUN;
            pc_reg        <= '0;
            pend_addr_reg <= '0;
            count_reg     <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pm_addr;
            if (run_cycle && hold) begin
                pend_addr_reg <= run_addr;
            end
            if (run_cycle && !hold && count_reg != 16'hFFFF) begin
                count_reg <= count_reg + 16'd1;
            end
        end
    end

    assign pc          = pc_reg;
    assign instr_count = count_reg;

endmodule
